// File: rtl/dram_axi_pkg.sv
// Shared widths, response codes, FSM state types and request checking for the
// DRAM-side AXI line responder.
package dram_axi_pkg;

  localparam int LINE_BITS = 512;
  localparam int STRB_BITS = 64;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  // A request is rejected when its line number is beyond the store or it asks for a burst.
  function automatic logic req_err(input logic [31:0] addr, input logic [1:0] len,
                                   input int lines);
    return ({6'b0, addr[31:6]} >= lines) || (len != 2'd0);
  endfunction

endpackage

// File: rtl/dram_axi_responder_if.sv
// Single-beat AXI line channels between the L2 master and the DRAM responder.
interface dram_axi_responder_if;
  import dram_axi_pkg::*;

  logic [31:0]          ar_addr;
  logic                 ar_valid;
  logic                 ar_ready;
  logic [1:0]           ar_len;
  logic [1:0]           ar_size;
  logic [1:0]           ar_burst;
  logic [LINE_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ready;
  logic                 r_last;
  logic                 r_resp;
  logic [31:0]          aw_addr;
  logic                 aw_valid;
  logic                 aw_ready;
  logic [1:0]           aw_len;
  logic [1:0]           aw_size;
  logic [1:0]           aw_burst;
  logic [LINE_BITS-1:0] w_data;
  logic [STRB_BITS-1:0] w_strb;
  logic                 w_valid;
  logic                 w_ready;
  logic                 w_last;
  logic                 b_valid;
  logic                 b_ready;
  logic                 b_resp;

  modport slave (
    input  ar_addr, ar_valid, ar_len, ar_size, ar_burst, r_ready,
    input  aw_addr, aw_valid, aw_len, aw_size, aw_burst,
    input  w_data, w_strb, w_valid, w_last, b_ready,
    output ar_ready, r_data, r_valid, r_last, r_resp,
    output aw_ready, w_ready, b_valid, b_resp
  );

  modport master (
    output ar_addr, ar_valid, ar_len, ar_size, ar_burst, r_ready,
    output aw_addr, aw_valid, aw_len, aw_size, aw_burst,
    output w_data, w_strb, w_valid, w_last, b_ready,
    input  ar_ready, r_data, r_valid, r_last, r_resp,
    input  aw_ready, w_ready, b_valid, b_resp
  );

endinterface

// File: rtl/dram_line_store.sv
// Line-addressed store: byte-enable synchronous write, registered read, and a
// write-first merge when a read and a write hit the same line on one edge.
module dram_line_store
  import dram_axi_pkg::*;
#(
  parameter int MEM_LINES = 1024,
  localparam int IDX_W = $clog2(MEM_LINES)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 we,
  input  logic [IDX_W-1:0]     widx,
  input  logic [LINE_BITS-1:0] wdata,
  input  logic [STRB_BITS-1:0] wstrb,
  input  logic                 re,
  input  logic [IDX_W-1:0]     ridx,
  output logic [LINE_BITS-1:0] rdata
);

  logic [LINE_BITS-1:0] mem [MEM_LINES];

  function automatic logic [LINE_BITS-1:0] merge_line(input logic [LINE_BITS-1:0] old_line,
                                                      input logic [LINE_BITS-1:0] new_line,
                                                      input logic [STRB_BITS-1:0] strb);
    logic [LINE_BITS-1:0] m;
    m = old_line;
    for (int i = 0; i < STRB_BITS; i++)
      if (strb[i]) m[8*i +: 8] = new_line[8*i +: 8];
    return m;
  endfunction

  always_ff @(posedge clock) begin
    if (we)
      for (int i = 0; i < STRB_BITS; i++)
        if (wstrb[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      rdata <= '0;
    else if (re)
      rdata <= (we && (widx == ridx)) ? merge_line(mem[ridx], wdata, wstrb) : mem[ridx];
  end

endmodule

// File: rtl/dram_axi_responder.sv
// DRAM endpoint for the L2 memory port: independent read and write FSMs serving
// single-beat line requests from dram_line_store after fixed latencies.
module dram_axi_responder
  import dram_axi_pkg::*;
#(
  parameter int MEM_LINES     = 1024,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  dram_axi_responder_if.slave  axi
);

  localparam int IDX_W   = $clog2(MEM_LINES);
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

  // Holds the readies low until the first edge after reset releases.
  logic live;

  rd_state_t            rd_state;
  logic [CNT_W-1:0]     rd_cnt;
  logic                 rd_err;
  logic [IDX_W-1:0]     rd_idx;
  logic                 ar_hs, ar_err_now, rd_sample, rd_sample_err;
  logic [IDX_W-1:0]     rd_sample_idx;
  logic [LINE_BITS-1:0] store_rdata;

  wr_state_t            wr_state;
  logic [CNT_W-1:0]     wr_cnt;
  logic                 aw_got, w_got, wr_err;
  logic [IDX_W-1:0]     wr_idx;
  logic [LINE_BITS-1:0] wr_data;
  logic [STRB_BITS-1:0] wr_strb;
  logic                 aw_hs, w_hs, aw_err_now, wr_both, commit, cur_err;
  logic [IDX_W-1:0]     cur_idx;
  logic [LINE_BITS-1:0] cur_data;
  logic [STRB_BITS-1:0] cur_strb;

  logic unused_inputs;
  assign unused_inputs = ^{axi.ar_size, axi.ar_burst, axi.aw_size, axi.aw_burst, axi.w_last,
                           axi.ar_addr[5:0], axi.aw_addr[5:0]};

  assign ar_hs         = axi.ar_valid && axi.ar_ready;
  assign ar_err_now    = req_err(axi.ar_addr, axi.ar_len, MEM_LINES);
  assign rd_sample     = ((rd_state == R_WAIT) && (rd_cnt == '0)) || (ar_hs && (READ_LATENCY == 1));
  assign rd_sample_idx = (rd_state == R_IDLE) ? axi.ar_addr[6 +: IDX_W] : rd_idx;
  assign rd_sample_err = (rd_state == R_IDLE) ? ar_err_now : rd_err;

  assign aw_hs      = axi.aw_valid && axi.aw_ready;
  assign w_hs       = axi.w_valid && axi.w_ready;
  assign aw_err_now = req_err(axi.aw_addr, axi.aw_len, MEM_LINES);
  assign wr_both    = (wr_state == W_IDLE) && (aw_got || aw_hs) && (w_got || w_hs);
  assign commit     = ((wr_state == W_WAIT) && (wr_cnt == '0)) || (wr_both && (WRITE_LATENCY == 1));
  // Captured values win once held; the live channel feeds a same-edge commit.
  assign cur_idx    = aw_got ? wr_idx  : axi.aw_addr[6 +: IDX_W];
  assign cur_err    = aw_got ? wr_err  : aw_err_now;
  assign cur_data   = w_got  ? wr_data : axi.w_data;
  assign cur_strb   = w_got  ? wr_strb : axi.w_strb;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      live     <= 1'b0;
      rd_state <= R_IDLE;
      rd_cnt   <= '0;
      rd_err   <= 1'b0;
    end else begin
      live <= 1'b1;
      case (rd_state)
        R_IDLE: if (ar_hs) begin
          rd_err   <= ar_err_now;
          rd_cnt   <= RD_LOAD;
          rd_state <= (READ_LATENCY == 1) ? R_RESP : R_WAIT;
        end
        R_WAIT: if (rd_cnt == '0) rd_state <= R_RESP;
                else              rd_cnt   <= rd_cnt - 1'b1;
        R_RESP: if (axi.r_ready) rd_state <= R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_state <= W_IDLE;
      wr_cnt   <= '0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_got <= 1'b1;
            wr_err <= aw_err_now;
          end
          if (w_hs) w_got <= 1'b1;
          if (wr_both) begin
            wr_cnt   <= WR_LOAD;
            wr_state <= (WRITE_LATENCY == 1) ? W_RESP : W_WAIT;
          end
        end
        W_WAIT: if (wr_cnt == '0) wr_state <= W_RESP;
                else              wr_cnt   <= wr_cnt - 1'b1;
        W_RESP: if (axi.b_ready) begin
          wr_state <= W_IDLE;
          aw_got   <= 1'b0;
          w_got    <= 1'b0;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (ar_hs) rd_idx <= axi.ar_addr[6 +: IDX_W];
    if (aw_hs) wr_idx <= axi.aw_addr[6 +: IDX_W];
    if (w_hs) begin
      wr_data <= axi.w_data;
      wr_strb <= axi.w_strb;
    end
  end

  dram_line_store #(.MEM_LINES(MEM_LINES)) u_store (
    .clock (clock),
    .reset (reset),
    .we    (commit && !cur_err),
    .widx  (cur_idx),
    .wdata (cur_data),
    .wstrb (cur_strb),
    .re    (rd_sample && !rd_sample_err),
    .ridx  (rd_sample_idx),
    .rdata (store_rdata)
  );

  assign axi.ar_ready = live && (rd_state == R_IDLE);
  assign axi.r_valid  = (rd_state == R_RESP);
  assign axi.r_last   = axi.r_valid;
  assign axi.r_resp   = (axi.r_valid && rd_err) ? RESP_ERR : RESP_OKAY;
  assign axi.r_data   = rd_err ? '0 : store_rdata;
  assign axi.aw_ready = live && (wr_state == W_IDLE) && !aw_got;
  assign axi.w_ready  = live && (wr_state == W_IDLE) && !w_got;
  assign axi.b_valid  = (wr_state == W_RESP);
  assign axi.b_resp   = (axi.b_valid && wr_err) ? RESP_ERR : RESP_OKAY;

endmodule

// File: tb/tb_dram_axi_responder.sv
// Directed bench for dram_axi_responder with READ_LATENCY=4, WRITE_LATENCY=2.
module tb_dram_axi_responder;
  import dram_axi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dram_axi_responder_if axi();

  dram_axi_responder #(.MEM_LINES(1024), .READ_LATENCY(4), .WRITE_LATENCY(2)) dut (
    .clock (clk),
    .reset (rst_n),
    .axi   (axi.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_d(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges after the AR handshake edge until r_valid is seen.
  task automatic start_read(input logic [31:0] addr, input logic [1:0] len, output int lat);
    axi.ar_addr  = addr;
    axi.ar_len   = len;
    axi.ar_valid = 1'b1;
    chk_b("ar_ready_idle", axi.ar_ready, 1'b1);
    tick();
    axi.ar_valid = 1'b0;
    lat = 0;
    while (!axi.r_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_read();
    axi.r_ready = 1'b1;
    tick();
    axi.r_ready = 1'b0;
    chk_b("r_valid_after_accept", axi.r_valid, 1'b0);
    chk_b("ar_ready_after_accept", axi.ar_ready, 1'b1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [511:0] data,
                          input logic [63:0] strb, output int lat);
    axi.aw_addr  = addr;
    axi.aw_len   = 2'd0;
    axi.w_data   = data;
    axi.w_strb   = strb;
    axi.aw_valid = 1'b1;
    axi.w_valid  = 1'b1;
    chk_b("aw_ready_idle", axi.aw_ready, 1'b1);
    chk_b("w_ready_idle", axi.w_ready, 1'b1);
    tick();
    axi.aw_valid = 1'b0;
    axi.w_valid  = 1'b0;
    chk_b("aw_ready_drop", axi.aw_ready, 1'b0);
    chk_b("w_ready_drop", axi.w_ready, 1'b0);
    lat = 0;
    while (!axi.b_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_write();
    axi.b_ready = 1'b1;
    tick();
    axi.b_ready = 1'b0;
    chk_b("b_valid_after_accept", axi.b_valid, 1'b0);
  endtask

  logic [511:0] line_a5, line_part, line_5a, line_96, line_ff, line_11, line_77, line_mix;
  int lat;

  initial begin
    line_a5   = {64{8'hA5}};
    line_part = {{63{8'hA5}}, 8'h3C};
    line_5a   = {64{8'h5A}};
    line_96   = {64{8'h96}};
    line_ff   = {64{8'hFF}};
    line_11   = {64{8'h11}};
    line_77   = {{32{8'h00}}, {32{8'h77}}};
    line_mix  = {{32{8'h11}}, {32{8'h77}}};

    axi.ar_addr = '0; axi.ar_valid = 1'b0; axi.ar_len = '0; axi.ar_size = 2'd2;
    axi.ar_burst = 2'd1; axi.r_ready = 1'b0;
    axi.aw_addr = '0; axi.aw_valid = 1'b0; axi.aw_len = '0; axi.aw_size = 2'd2;
    axi.aw_burst = 2'd1; axi.w_data = '0; axi.w_strb = '0; axi.w_valid = 1'b0;
    axi.w_last = 1'b1; axi.b_ready = 1'b0;

    // Reset state and release
    #1;
    chk_b("rst_ar_ready", axi.ar_ready, 1'b0);
    chk_b("rst_aw_ready", axi.aw_ready, 1'b0);
    chk_b("rst_w_ready", axi.w_ready, 1'b0);
    chk_b("rst_r_valid", axi.r_valid, 1'b0);
    chk_b("rst_r_last", axi.r_last, 1'b0);
    chk_b("rst_b_valid", axi.b_valid, 1'b0);
    chk_b("rst_r_resp", axi.r_resp, 1'b0);
    chk_b("rst_b_resp", axi.b_resp, 1'b0);
    chk_d("rst_r_data", axi.r_data, 512'd0);
    tick();
    tick();
    rst_n = 1'b1;
    chk_b("ar_ready_before_first_edge", axi.ar_ready, 1'b0);
    tick();
    chk_b("ar_ready_first_edge", axi.ar_ready, 1'b1);
    chk_b("aw_ready_first_edge", axi.aw_ready, 1'b1);
    chk_b("w_ready_first_edge", axi.w_ready, 1'b1);

    // Full write then read back
    do_write(32'h0000_0040, line_a5, {64{1'b1}}, lat);
    chk_i("full_wr_latency", lat, 2);
    chk_b("full_wr_b_resp", axi.b_resp, RESP_OKAY);
    finish_write();
    start_read(32'h0000_0040, 2'd0, lat);
    chk_i("full_rd_latency", lat, 4);
    chk_d("full_rd_data", axi.r_data, line_a5);
    chk_b("full_rd_resp", axi.r_resp, RESP_OKAY);
    chk_b("full_rd_last", axi.r_last, 1'b1);
    finish_read();

    // Partial write merges byte 0 only
    do_write(32'h0000_0040, {{63{8'h00}}, 8'h3C}, 64'h1, lat);
    chk_i("part_wr_latency", lat, 2);
    finish_write();
    start_read(32'h0000_0040, 2'd0, lat);
    chk_d("part_rd_data", axi.r_data, line_part);
    finish_read();

    // W three cycles ahead of AW
    axi.w_data = line_5a; axi.w_strb = {64{1'b1}}; axi.w_valid = 1'b1;
    tick();
    axi.w_valid = 1'b0;
    chk_b("w_first_w_ready_drop", axi.w_ready, 1'b0);
    chk_b("w_first_aw_ready_held", axi.aw_ready, 1'b1);
    tick();
    tick();
    chk_b("w_first_w_ready_still_low", axi.w_ready, 1'b0);
    axi.aw_addr = 32'h0000_00C0; axi.aw_len = 2'd0; axi.aw_valid = 1'b1;
    tick();
    axi.aw_valid = 1'b0;
    chk_b("w_first_aw_ready_drop", axi.aw_ready, 1'b0);
    lat = 0;
    while (!axi.b_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk_i("w_first_latency", lat, 2);
    chk_b("w_first_b_resp", axi.b_resp, RESP_OKAY);
    finish_write();
    tick();
    chk_b("w_first_single_b", axi.b_valid, 1'b0);
    start_read(32'h0000_00C0, 2'd0, lat);
    chk_d("w_first_rd_data", axi.r_data, line_5a);
    finish_read();

    // Same-cycle AW and W, then error requests; line 1024 aliases line 0's index
    do_write(32'h0000_0000, line_96, {64{1'b1}}, lat);
    chk_i("same_cycle_latency", lat, 2);
    finish_write();
    tick();
    chk_b("same_cycle_single_b", axi.b_valid, 1'b0);
    start_read(32'h0001_0000, 2'd0, lat);
    chk_i("oob_rd_latency", lat, 4);
    chk_b("oob_rd_resp", axi.r_resp, RESP_ERR);
    chk_d("oob_rd_data", axi.r_data, 512'd0);
    finish_read();
    start_read(32'h0000_0040, 2'd1, lat);
    chk_b("len_rd_resp", axi.r_resp, RESP_ERR);
    chk_d("len_rd_data", axi.r_data, 512'd0);
    finish_read();
    do_write(32'h0001_0000, line_ff, {64{1'b1}}, lat);
    chk_b("oob_wr_resp", axi.b_resp, RESP_ERR);
    finish_write();
    start_read(32'h0000_0000, 2'd0, lat);
    chk_d("oob_wr_store_unchanged", axi.r_data, line_96);
    chk_b("oob_wr_line0_resp", axi.r_resp, RESP_OKAY);
    finish_read();

    // Read back-pressure
    start_read(32'h0000_0040, 2'd0, lat);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_b("hold_r_valid", axi.r_valid, 1'b1);
      chk_d("hold_r_data", axi.r_data, line_part);
      chk_b("hold_ar_ready", axi.ar_ready, 1'b0);
    end
    finish_read();

    // Write commit and read sample of line 2 on the same edge
    do_write(32'h0000_0080, line_11, {64{1'b1}}, lat);
    finish_write();
    axi.ar_addr = 32'h0000_0080; axi.ar_len = 2'd0; axi.ar_valid = 1'b1;
    tick();
    axi.ar_valid = 1'b0;
    tick();
    axi.aw_addr = 32'h0000_0080; axi.aw_len = 2'd0; axi.aw_valid = 1'b1;
    axi.w_data = line_77; axi.w_strb = 64'h0000_0000_FFFF_FFFF; axi.w_valid = 1'b1;
    tick();
    axi.aw_valid = 1'b0;
    axi.w_valid = 1'b0;
    tick();
    chk_b("coll_r_not_yet", axi.r_valid, 1'b0);
    tick();
    chk_b("coll_r_valid", axi.r_valid, 1'b1);
    chk_b("coll_b_valid", axi.b_valid, 1'b1);
    chk_d("coll_bypass_data", axi.r_data, line_mix);
    axi.b_ready = 1'b1;
    finish_read();
    axi.b_ready = 1'b0;
    start_read(32'h0000_0080, 2'd0, lat);
    chk_d("coll_stored_data", axi.r_data, line_mix);
    finish_read();

    // Reset while the read is waiting
    axi.ar_addr = 32'h0000_0040; axi.ar_len = 2'd0; axi.ar_valid = 1'b1;
    tick();
    axi.ar_valid = 1'b0;
    tick();
    chk_b("mid_rst_wait", axi.r_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_b("mid_rst_ar_ready", axi.ar_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    chk_b("mid_rst_release_ar_ready", axi.ar_ready, 1'b0);
    tick();
    chk_b("mid_rst_first_edge_ar_ready", axi.ar_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk_b("mid_rst_no_r_valid", axi.r_valid, 1'b0);
      tick();
    end
    start_read(32'h0000_0040, 2'd0, lat);
    chk_i("post_rst_latency", lat, 4);
    chk_d("post_rst_store_kept", axi.r_data, line_part);
    finish_read();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dram_axi_responder.md
Name: dram_axi_responder

Overview:
- DRAM-side responder for the L2 cache's memory port.
- Accepts single-beat 512-bit line reads (AR/R) and writes (AW/W/B) from the L2 master.
- Services them from an internal line-addressed store with fixed, parameterised latency.
- Used as the memory endpoint in L2 simulation and as the template for the real memory-controller front end.

Parameters:
- MEM_LINES, 1024: number of 64-byte lines in the store; power of two.
- READ_LATENCY, 4: cycles from the AR handshake edge to r_valid rising; minimum 1.
- WRITE_LATENCY, 2: cycles from the later of the AW/W handshakes to b_valid rising; minimum 1.

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- ar_addr  in  32  read line address; bits [5:0] ignored
- ar_valid  in  1  read request valid
- ar_ready  out  1  responder can accept a read
- ar_len  in  2  burst length-1; only 0 supported
- ar_size  in  2  ignored
- ar_burst  in  2  ignored
- r_data  out  512  read line
- r_valid  out  1  read data valid
- r_ready  in  1  master accepts read data
- r_last  out  1  always equals r_valid
- r_resp  out  1  0=OKAY, 1=error
- aw_addr  in  32  write line address; bits [5:0] ignored
- aw_valid  in  1  write address valid
- aw_ready  out  1  responder can accept a write address
- aw_len  in  2  only 0 supported
- aw_size  in  2  ignored
- aw_burst  in  2  ignored
- w_data  in  512  write line
- w_strb  in  64  byte enables; bit i covers w_data[8i+7:8i]
- w_valid  in  1  write data valid
- w_ready  out  1  responder can accept write data
- w_last  in  1  ignored; single beat
- b_valid  out  1  write response valid
- b_ready  in  1  master accepts write response
- b_resp  out  1  0=OKAY, 1=error

Behaviour:
- Reset (reset low, asynchronous):
  - Both FSMs go to IDLE.
  - ar_ready, aw_ready, w_ready, r_valid, r_last, b_valid, r_resp, b_resp are 0; r_data is 0.
  - Store contents are not cleared.
  - Readies rise on the first clock edge after reset deasserts.
  - A reset mid-transaction abandons the transaction with no response and no store write.
- Line index is addr[6+$clog2(MEM_LINES)-1:6].
- A request is in error if addr[31:6] >= MEM_LINES or len != 0.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: ar_ready=1. On ar_valid&&ar_ready, capture the address and error flag, load the counter with READ_LATENCY-1, go to R_WAIT. If READ_LATENCY=1, go directly to R_RESP.
  - R_WAIT: decrement the counter; on the edge where it reaches 0, sample the store into r_data and go to R_RESP. On error, r_data=0 and r_resp=1.
  - R_RESP: r_valid=1, r_last=1. r_data and r_resp stay stable until r_valid&&r_ready, then return to R_IDLE. ar_ready re-asserts the following cycle, so at most one read is outstanding.
- Write FSM, states W_IDLE, W_WAIT, W_RESP:
  - W_IDLE: aw_ready=1 until AW is captured; w_ready=1 until W is captured. AW and W may arrive in either order or in the same cycle. Each ready drops the cycle after its own handshake.
  - When both are captured, load the counter with WRITE_LATENCY-1 and go to W_WAIT.
  - On the edge where the counter reaches 0, commit to the store the bytes with w_strb=1; other bytes are unchanged. Error requests do not write the store. Go to W_RESP.
  - W_RESP: b_valid=1 with b_resp until b_ready, then return to W_IDLE.
- The read and write channels are independent and may be active at the same time.
- Collision rule: if a write commits and a read samples the same line on the same edge, the read returns the post-write data (write-first bypass with byte merge).
- Counters are $clog2(max latency)+1 bits wide and never wrap. Latencies are measured from the handshake edge.

Decomposition:
- Package dram_axi_pkg:
  - LINE_BITS=512, STRB_BITS=64
  - RESP_OKAY=1'b0, RESP_ERR=1'b1
  - enums rd_state_t and wr_state_t
- Sub-module dram_line_store: MEM_LINES x 512-bit array with byte-enable synchronous write and registered read, including write-first bypass on same-index collision.

Test Plan:
- Write addr 0x0000_0040, data all 0xA5, strb all 1s; then read 0x40 → b_resp=0 exactly WRITE_LATENCY cycles after the W handshake; r_valid exactly 4 cycles after AR; r_data all 0xA5; r_resp=0; r_last=1.
- Partial write to 0x40 with strb=64'h1 and data byte 0=0x3C → readback byte 0=0x3C, bytes 1..63 still 0xA5.
- W presented 3 cycles before AW; then AW and W in the same cycle → both complete with exactly one b_valid each; aw_ready/w_ready drop individually after their own handshake.
- Read of addr 0x0001_0000 (line 1024), and an ar_len=1 request → r_resp=1, r_data=0; a write to line 1024 gets b_resp=1 and the store is unchanged.
- Hold r_ready=0 for 5 cycles → r_valid and r_data stay stable, ar_ready stays 0; after acceptance, ar_ready=1 the next cycle.
- Write commit and read sample to line 2 on the same edge → read returns the new data.
- Assert reset during R_WAIT → r_valid never rises; ar_ready=1 on the first edge after release.
